// File: rtl/syscall_print_sequencer_if.sv
// Syscall sequencer bus: M-stage syscall taps, data-memory read port, console byte stream, hazard outputs.
interface syscall_print_sequencer_if;
  logic        sig_syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_read_data;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        stall;
  logic        sig_exit;
  logic        busy;

  modport master (
    output sig_syscall, v0, a0, mem_read_data, char_ready,
    input  mem_rd_en, mem_addr, char_data, char_valid, stall, sig_exit, busy
  );

  modport slave (
    input  sig_syscall, v0, a0, mem_read_data, char_ready,
    output mem_rd_en, mem_addr, char_data, char_valid, stall, sig_exit, busy
  );
endinterface

// File: rtl/syscall_print_sequencer.sv
// Multi-cycle syscall servicer: print string (4), print char (11), exit (10); freezes the pipeline while busy.
// Optional SYSCALL_PRINT_HEX_EN adds print-hex (34): "0x" plus 8 lowercase nibbles, MSB first.
module syscall_print_sequencer #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  syscall_print_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EMIT  = 3'd2,
    DONE  = 3'd3,
    HALT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       char_q, char_d;
  logic             single_q, single_d;
  logic             svc_ok;
  logic             accept;
  logic [7:0]       mem_byte;

`ifdef SYSCALL_PRINT_HEX_EN
  localparam logic [31:0] SVC_PRINT_HEX = 32'd34;

  logic        hex_q, hex_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  idx_q, idx_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'(8'h30 + {4'h0, nib}) : 8'(8'h57 + {4'h0, nib});
  endfunction
`endif

  // Recognised service codes
  always_comb begin
    svc_ok = (bus.v0 == SVC_PRINT_STR) || (bus.v0 == SVC_EXIT) || (bus.v0 == SVC_PRINT_CHAR);
`ifdef SYSCALL_PRINT_HEX_EN
    svc_ok = svc_ok || (bus.v0 == SVC_PRINT_HEX);
`endif
  end

  assign accept = rst_n & bus.sig_syscall & (state_q == IDLE) & svc_ok;

  // Big-endian lane select: byte 0 of a word lives in bits [31:24]
  always_comb begin
    unique case (ptr_q[1:0])
      2'd0:    mem_byte = bus.mem_read_data[31:24];
      2'd1:    mem_byte = bus.mem_read_data[23:16];
      2'd2:    mem_byte = bus.mem_read_data[15:8];
      default: mem_byte = bus.mem_read_data[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    char_d   = char_q;
    single_d = single_q;
`ifdef SYSCALL_PRINT_HEX_EN
    hex_d    = hex_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.v0)
            SVC_PRINT_STR: begin
              ptr_d   = bus.a0;
              count_d = '0;
              state_d = FETCH;
            end
            SVC_PRINT_CHAR: begin
              char_d   = bus.a0[7:0];
              single_d = 1'b1;
              state_d  = EMIT;
            end
            SVC_EXIT: state_d = HALT;
`ifdef SYSCALL_PRINT_HEX_EN
            SVC_PRINT_HEX: begin
              hex_d   = 1'b1;
              shift_d = bus.a0;
              idx_d   = 4'd0;
              char_d  = 8'h30;
              state_d = EMIT;
            end
`endif
            default: state_d = IDLE;
          endcase
        end
      end

      FETCH: begin
        if (mem_byte == 8'h00) begin
          state_d = DONE;
        end else begin
          char_d  = mem_byte;
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (bus.char_ready) begin
          if (single_q) begin
            single_d = 1'b0;
            state_d  = DONE;
          end
`ifdef SYSCALL_PRINT_HEX_EN
          // '0','x' then one nibble per transfer; idx 9 is the last character
          else if (hex_q) begin
            if (idx_q == 4'd9) begin
              hex_d   = 1'b0;
              state_d = DONE;
            end else begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd0) begin
                char_d = 8'h78;
              end else begin
                char_d  = hex_ascii(shift_q[31:28]);
                shift_d = {shift_q[27:0], 4'h0};
              end
            end
          end
`endif
          else begin
            ptr_d   = ptr_q + 32'd1;
            count_d = count_q + CNT_W'(1);
            state_d = (count_q + CNT_W'(1) == CNT_W'(MAX_LEN)) ? DONE : FETCH;
          end
        end
      end

      DONE:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      char_q   <= '0;
      single_q <= 1'b0;
`ifdef SYSCALL_PRINT_HEX_EN
      hex_q    <= 1'b0;
      shift_q  <= '0;
      idx_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      char_q   <= char_d;
      single_q <= single_d;
`ifdef SYSCALL_PRINT_HEX_EN
      hex_q    <= hex_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
`endif
    end
  end

  // Stall is combinational so the pipeline freezes in the cycle the syscall is seen
  assign bus.stall      = accept | (state_q inside {FETCH, EMIT, HALT});
  assign bus.mem_rd_en  = (state_q == FETCH);
  assign bus.mem_addr   = (state_q == FETCH) ? ptr_q : 32'd0;
  assign bus.char_valid = (state_q == EMIT);
  assign bus.char_data  = char_q;
  assign bus.sig_exit   = (state_q == HALT);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_syscall_print_sequencer.sv
// Directed bench for syscall_print_sequencer with a queue-based character model and per-cycle compare.
module tb_syscall_print_sequencer;

  localparam int unsigned MAX_LEN  = 256;
  localparam int unsigned LIMIT    = 2000;
  localparam logic [31:0] HI_ADDR  = 32'h7FF0_0000;
  localparam logic [31:0] BUF_BASE = 32'h0000_1001;
  localparam int unsigned BUF_LEN  = 300;

  logic clk;
  logic rst_n;
  syscall_print_sequencer_if bus ();

  syscall_print_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          str_active = 0;
  logic [31:0] exp_addr   = 0;
  bit          held       = 0;
  logic [7:0]  held_data  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: "Hi\0" at HI_ADDR, a NUL-free printable buffer at BUF_BASE, zeros elsewhere
  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a >= HI_ADDR && a < HI_ADDR + 32'd4) begin
      if (a[1:0] == 2'd0) return 8'h48;
      if (a[1:0] == 2'd1) return 8'h69;
      return 8'h00;
    end
    if (a >= BUF_BASE && a < BUF_BASE + 32'(BUF_LEN))
      return 8'(32'h21 + ((a - BUF_BASE) % 32'd94));
    return 8'h00;
  endfunction

  always_comb begin
    logic [31:0] w;
    w = {bus.mem_addr[31:2], 2'b00};
    bus.mem_read_data = {rd_byte(w), rd_byte(w + 32'd1), rd_byte(w + 32'd2), rd_byte(w + 32'd3)};
  end

  // Expected output stream for one syscall, straight from the service definitions
  task automatic load_model(input logic [31:0] v, input logic [31:0] a);
    exp_q.delete();
    got_q.delete();
    str_active = 0;
    if (v == 32'd4) begin
      str_active = 1;
      exp_addr   = a;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        logic [7:0] b;
        b = rd_byte(a + 32'(i));
        if (b == 8'h00) break;
        exp_q.push_back(b);
      end
    end else if (v == 32'd11) begin
      exp_q.push_back(a[7:0]);
    end
`ifdef SYSCALL_PRINT_HEX_EN
    else if (v == 32'd34) begin
      string s;
      s = $sformatf("0x%08h", a);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    end
`endif
  endtask

  // Per-cycle compare: memory address, character order/values, hold while not ready
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd_en) begin
        check("mem_rd_outside_string", 32'(str_active), 32'd1);
        check("mem_addr", bus.mem_addr, exp_addr);
      end
      if (held && bus.char_valid)
        check("char_hold", 32'(bus.char_data), 32'(held_data));
      if (bus.char_valid && bus.char_ready) begin
        got_q.push_back(bus.char_data);
        if (exp_q.size() == 0) begin
          check("unexpected_char", 32'(bus.char_data), 32'hFFFF_FFFF);
        end else begin
          check("char_data", 32'(bus.char_data), 32'(exp_q.pop_front()));
        end
        if (str_active) exp_addr = exp_addr + 32'd1;
      end
      held      = bus.char_valid && !bus.char_ready;
      held_data = bus.char_data;
    end else begin
      held = 0;
    end
  end

  // Issue a syscall from posedge+1 and hold it in M until the DONE cycle has passed
  task automatic run_call(input logic [31:0] v, input logic [31:0] a, input string tag);
    bit done;
    load_model(v, a);
    bus.sig_syscall = 1'b1;
    bus.v0          = v;
    bus.a0          = a;
    @(negedge clk);
    check({tag, "_stall_same_cycle"}, 32'(bus.stall), 32'd1);
    done = 0;
    for (int c = 0; c < int'(LIMIT) && !done; c++) begin
      @(negedge clk);
      if (!bus.stall) done = 1;
    end
    check({tag, "_reached_done"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_remaining_chars"}, 32'(exp_q.size()), 32'd0);
    str_active = 0;
    @(posedge clk); #1;
    bus.sig_syscall = 1'b0;
  endtask

  task automatic check_ignored(input logic [31:0] v, input string tag);
    bus.sig_syscall = 1'b1;
    bus.v0          = v;
    bus.a0          = 32'hDEAD_BEEF;
    @(negedge clk);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_valid"}, 32'(bus.char_valid | bus.mem_rd_en), 32'd0);
    end
    @(posedge clk); #1;
    bus.sig_syscall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.sig_syscall = 1'b0;
    bus.v0          = 32'd0;
    bus.a0          = 32'd0;
    bus.char_ready  = 1'b1;
    #3;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_exit", 32'(bus.sig_exit), 32'd0);
    check("rst_valid", 32'(bus.char_valid), 32'd0);
    check("rst_char", 32'(bus.char_data), 32'd0);
    check("rst_mem", 32'(bus.mem_rd_en) | bus.mem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "Hi\0" with ready high
    run_call(32'd4, HI_ADDR, "hi");
    check("hi_count", 32'(got_q.size()), 32'd2);
    check("hi_char0", 32'(got_q[0]), 32'h48);
    check("hi_char1", 32'(got_q[1]), 32'h69);

    check_ignored(32'd5, "unrec5");

    // Single char with console stalled for three cycles
    load_model(32'd11, 32'h41);
    bus.char_ready  = 1'b0;
    bus.sig_syscall = 1'b1;
    bus.v0          = 32'd11;
    bus.a0          = 32'h0000_0041;
    @(negedge clk);
    check("pc_stall_same_cycle", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pc_valid_waiting", 32'(bus.char_valid), 32'd1);
      check("pc_data_waiting", 32'(bus.char_data), 32'h41);
    end
    @(posedge clk); #1;
    bus.char_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pc_done_stall", 32'(bus.stall), 32'd0);
    check("pc_done_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.sig_syscall = 1'b0;
    @(negedge clk);
    check("pc_no_retrigger", 32'(bus.busy), 32'd0);
    check("pc_count", 32'(got_q.size()), 32'd1);

    // Back-to-back: new syscall in M right after DONE
    @(posedge clk); #1;
    run_call(32'd11, 32'h0000_0042, "b2b_a");
    run_call(32'd4, HI_ADDR, "b2b_b");
    check("b2b_count", 32'(got_q.size()), 32'd2);
    @(negedge clk);
    check("b2b_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // Long unaligned buffer, truncated at MAX_LEN
    run_call(32'd4, BUF_BASE, "long");
    check("long_count", 32'(got_q.size()), 32'd256);
    check("long_first", 32'(got_q[0]), 32'h21);
    check("long_last", 32'(got_q[255]), 32'h64);

    // Print-hex
`ifdef SYSCALL_PRINT_HEX_EN
    run_call(32'd34, 32'hDEAD_BEEF, "hex");
    check("hex_count", 32'(got_q.size()), 32'd10);
    check("hex_c0", 32'(got_q[0]), 32'h30);
    check("hex_c1", 32'(got_q[1]), 32'h78);
    check("hex_c2", 32'(got_q[2]), 32'h64);
    check("hex_c9", 32'(got_q[9]), 32'h66);
`else
    check_ignored(32'd34, "hex_off");
`endif

    // Asynchronous reset in the middle of a string
    load_model(32'd4, BUF_BASE);
    bus.sig_syscall = 1'b1;
    bus.v0          = 32'd4;
    bus.a0          = BUF_BASE;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(negedge clk);
        if (c >= 4 && bus.char_valid) hit = 1;
      end
      check("midrst_in_emit", 32'(hit), 32'd1);
    end
    #2;
    rst_n           = 1'b0;
    bus.sig_syscall = 1'b0;
    exp_q.delete();
    str_active = 0;
    #1;
    check("midrst_valid", 32'(bus.char_valid), 32'd0);
    check("midrst_char", 32'(bus.char_data), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_mem", 32'(bus.mem_rd_en) | bus.mem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_call(32'd11, 32'h0000_005A, "post_rst");
    check("post_rst_count", 32'(got_q.size()), 32'd1);
    check("post_rst_char", 32'(got_q[0]), 32'h5A);

    // Exit: sticky halt until reset
    bus.sig_syscall = 1'b1;
    bus.v0          = 32'd10;
    bus.a0          = 32'd0;
    @(negedge clk);
    check("exit_stall_same_cycle", 32'(bus.stall), 32'd1);
    check("exit_not_yet", 32'(bus.sig_exit), 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("exit_hold", {29'd0, bus.stall, bus.sig_exit, bus.busy}, 32'd7);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("exit_rst", {29'd0, bus.stall, bus.sig_exit, bus.busy}, 32'd0);
    bus.sig_syscall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("exit_after_rst", {29'd0, bus.stall, bus.sig_exit, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
